// File: rtl/ifu_fetch.sv
// Instruction fetch stage and IF/ID pipeline register.
// Define IFU_DELAY_SLOT_EN for MIPS delay-slot behaviour; by default redirects squash the in-flight fetch.
module ifu_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        id_fetch_err
);

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] idpc4;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        redirect;
  logic        illegal;

  assign pc4       = pc + 32'd4;
  assign idpc4     = id_pc + 32'd4;
  assign imem_addr = pc;
  assign id_pc8    = id_pc + 32'd8;

  assign illegal = (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);

  // An invalid ID slot cannot request a redirect even if npc_sel glitches.
  always_comb begin
    target   = pc4;
    redirect = 1'b0;
    case (npc_sel)
      NPC_BR: begin
        target   = idpc4 + (br_offset << 2);
        redirect = br_taken;
      end
      NPC_J: begin
        target   = {idpc4[31:28], j_index, 2'b00};
        redirect = 1'b1;
      end
      NPC_JR: begin
        target   = jr_target;
        redirect = 1'b1;
      end
      default: begin
        target   = pc4;
        redirect = 1'b0;
      end
    endcase
    redirect = redirect && id_valid;
    next_pc  = redirect ? target : pc4;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc           <= PC_RESET;
      id_instr     <= 32'd0;
      id_pc        <= 32'd0;
      id_valid     <= 1'b0;
      id_fetch_err <= 1'b0;
    end else if (!stall) begin
      pc    <= next_pc;
      id_pc <= pc;
`ifdef IFU_DELAY_SLOT_EN
      id_instr     <= illegal ? 32'd0 : imem_rdata;
      id_valid     <= 1'b1;
      id_fetch_err <= illegal;
`else
      if (redirect) begin
        id_instr     <= 32'd0;
        id_valid     <= 1'b0;
        id_fetch_err <= 1'b0;
      end else begin
        id_instr     <= illegal ? 32'd0 : imem_rdata;
        id_valid     <= 1'b1;
        id_fetch_err <= illegal;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus randomized traffic against a behavioural model.
// Honours IFU_DELAY_SLOT_EN the same way the design does.
module tb_ifu_fetch;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IMEM_LO  = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI  = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [31:0] br_offset;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic        id_valid;
  logic        id_fetch_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_instr, m_idpc;
  logic        m_valid, m_err;

  ifu_fetch #(.PC_RESET(PC_RESET), .IMEM_LO(IMEM_LO), .IMEM_HI(IMEM_HI)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .npc_sel(npc_sel),
    .br_taken(br_taken), .br_offset(br_offset), .j_index(j_index),
    .jr_target(jr_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc8(id_pc8),
    .id_valid(id_valid), .id_fetch_err(id_fetch_err)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'h0000_FFFF;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0000_FFFF;
  endfunction

  task automatic model_reset();
    m_pc = PC_RESET; m_instr = 0; m_idpc = 0; m_valid = 0; m_err = 0;
  endtask

  // Applies one unstalled/stalled clock edge to the model using the current inputs.
  task automatic model_edge();
    bit          legal, taken;
    logic [31:0] dest;
    if (stall) return;
    legal = (m_pc % 4 == 0) && (m_pc >= IMEM_LO) && (m_pc <= IMEM_HI);
    taken = 0;
    dest  = m_pc + 4;
    if (m_valid) begin
      if (npc_sel == 1 && br_taken) begin taken = 1; dest = m_idpc + 4 + br_offset * 4; end
      if (npc_sel == 2) begin taken = 1; dest = ((m_idpc + 4) & 32'hF000_0000) | ({6'd0, j_index} * 4); end
      if (npc_sel == 3) begin taken = 1; dest = jr_target; end
    end
    m_idpc = m_pc;
`ifdef IFU_DELAY_SLOT_EN
    m_instr = legal ? mem_word(m_pc) : 0; m_valid = 1; m_err = !legal;
`else
    if (taken) begin m_instr = 0; m_valid = 0; m_err = 0; end
    else begin m_instr = legal ? mem_word(m_pc) : 0; m_valid = 1; m_err = !legal; end
`endif
    m_pc = dest;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Leaves id_pc=addr with id_valid=1 and PC=addr+4.
  task automatic go_to(input logic [31:0] addr);
    stall = 0;
    if (!m_valid) begin npc_sel = 0; step(); end
    npc_sel = 3; jr_target = addr; step();
    npc_sel = 0; step();
  endtask

  task automatic test_reset();
    reset_n = 0; stall = 0; npc_sel = 0; br_taken = 0; br_offset = 0; j_index = 0; jr_target = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_addr !== 32'h3000) begin errors++; $display("FAIL reset_pc got %h exp %h", imem_addr, 32'h3000); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", id_instr); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_idpc got %h exp 0", id_pc); end
    checks++; if (id_pc8 !== 32'h8) begin errors++; $display("FAIL reset_idpc8 got %h exp 8", id_pc8); end
    checks++; if (id_valid !== 1'b0 || id_fetch_err !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", id_valid, id_fetch_err); end
    reset_n = 1;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (imem_addr !== 32'h3000 + 4 * i) begin errors++; $display("FAIL seq_pc got %h exp %h", imem_addr, 32'h3000 + 4 * i); end
      checks++; if (id_pc !== 32'h3000 + 4 * (i - 1)) begin errors++; $display("FAIL seq_idpc got %h exp %h", id_pc, 32'h3000 + 4 * (i - 1)); end
      checks++; if (id_pc8 !== 32'h3008 + 4 * (i - 1)) begin errors++; $display("FAIL seq_idpc8 got %h exp %h", id_pc8, 32'h3008 + 4 * (i - 1)); end
      checks++; if (id_instr !== mem_word(32'h3000 + 4 * (i - 1))) begin errors++; $display("FAIL seq_instr got %h exp %h", id_instr, mem_word(32'h3000 + 4 * (i - 1))); end
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid got %b exp 1", id_valid); end
    end
  endtask

  task automatic test_branch();
    go_to(32'h3004);
    checks++; if (id_pc !== 32'h3004 || imem_addr !== 32'h3008) begin errors++; $display("FAIL br_setup got %h/%h exp 3004/3008", id_pc, imem_addr); end
    npc_sel = 1; br_taken = 1; br_offset = 32'hFFFF_FFFE;
    step();
    npc_sel = 0; br_taken = 0;
    checks++; if (imem_addr !== 32'h3000) begin errors++; $display("FAIL br_target got %h exp %h", imem_addr, 32'h3000); end
    checks++; if (id_pc !== 32'h3008) begin errors++; $display("FAIL br_idpc got %h exp %h", id_pc, 32'h3008); end
`ifdef IFU_DELAY_SLOT_EN
    checks++; if (id_instr !== 32'h0000_CFF7 || id_valid !== 1'b1) begin errors++; $display("FAIL br_slot got %h/%b exp %h/1", id_instr, id_valid, 32'h0000_CFF7); end
`else
    checks++; if (id_instr !== 32'h0 || id_valid !== 1'b0) begin errors++; $display("FAIL br_squash got %h/%b exp 0/0", id_instr, id_valid); end
`endif
    // Not-taken branch behaves as sequential.
    go_to(32'h3010);
    npc_sel = 1; br_taken = 0; br_offset = 32'h10;
    step();
    npc_sel = 0;
    checks++; if (imem_addr !== 32'h3018 || id_valid !== 1'b1) begin errors++; $display("FAIL br_nt got %h/%b exp 3018/1", imem_addr, id_valid); end
  endtask

  task automatic test_jump();
    go_to(32'h3010);
    npc_sel = 2; j_index = 26'h0000C10;
    step();
    npc_sel = 0;
    checks++; if (imem_addr !== 32'h3040) begin errors++; $display("FAIL j_target got %h exp %h", imem_addr, 32'h3040); end
    if (!m_valid) step();
    npc_sel = 3; jr_target = 32'h3100;
    step();
    npc_sel = 0;
    checks++; if (imem_addr !== 32'h3100) begin errors++; $display("FAIL jr_target got %h exp %h", imem_addr, 32'h3100); end
  endtask

  task automatic test_stall_redirect();
    go_to(32'h3020);
    npc_sel = 2; j_index = 26'h0000C40; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_addr !== 32'h3024 || id_pc !== 32'h3020) begin errors++; $display("FAIL stall_hold got %h/%h exp 3024/3020", imem_addr, id_pc); end
      checks++; if (id_instr !== mem_word(32'h3020) || id_valid !== 1'b1) begin errors++; $display("FAIL stall_id got %h/%b exp %h/1", id_instr, id_valid, mem_word(32'h3020)); end
    end
    stall = 0;
    step();
    npc_sel = 0;
    checks++; if (imem_addr !== 32'h3100 || id_pc !== 32'h3024) begin errors++; $display("FAIL stall_release got %h/%h exp 3100/3024", imem_addr, id_pc); end
  endtask

  task automatic test_illegal();
    go_to(32'h3002);
    checks++; if (id_fetch_err !== 1'b1 || id_instr !== 32'h0 || id_valid !== 1'b1) begin errors++; $display("FAIL ill_align got %b/%h/%b exp 1/0/1", id_fetch_err, id_instr, id_valid); end
    go_to(32'h7000);
    checks++; if (id_fetch_err !== 1'b1 || id_instr !== 32'h0 || id_valid !== 1'b1) begin errors++; $display("FAIL ill_high got %b/%h/%b exp 1/0/1", id_fetch_err, id_instr, id_valid); end
    go_to(32'h2FFC);
    checks++; if (id_fetch_err !== 1'b1 || id_instr !== 32'h0) begin errors++; $display("FAIL ill_low got %b/%h exp 1/0", id_fetch_err, id_instr); end
    go_to(32'h6FFC);
    checks++; if (id_fetch_err !== 1'b0 || id_instr !== mem_word(32'h6FFC)) begin errors++; $display("FAIL ill_hi_edge got %b/%h exp 0/%h", id_fetch_err, id_instr, mem_word(32'h6FFC)); end
    checks++; if (imem_addr !== 32'h7000) begin errors++; $display("FAIL ill_pc_kept got %h exp 7000", imem_addr); end
  endtask

  task automatic test_async_reset();
    go_to(32'h303C);
    checks++; if (imem_addr !== 32'h3040) begin errors++; $display("FAIL ar_setup got %h exp 3040", imem_addr); end
    npc_sel = 3; jr_target = 32'h5000;
    #3;
    reset_n = 0;
    #1;
    checks++; if (imem_addr !== 32'h3000 || id_valid !== 1'b0) begin errors++; $display("FAIL ar_immediate got %h/%b exp 3000/0", imem_addr, id_valid); end
    checks++; if (id_pc8 !== 32'h8) begin errors++; $display("FAIL ar_idpc8 got %h exp 8", id_pc8); end
    model_reset();
    npc_sel = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    step();
    checks++; if (imem_addr !== 32'h3004 || id_pc !== 32'h3000) begin errors++; $display("FAIL ar_resume got %h/%h exp 3004/3000", imem_addr, id_pc); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      stall     = ($urandom % 4) == 0;
      npc_sel   = m_valid ? 2'($urandom % 4) : 2'd0;
      br_taken  = $urandom % 2;
      br_offset = 32'($urandom_range(0, 64)) - 32'd32;
      j_index   = 26'($urandom_range(32'h0BF0, 32'h1C10));
      jr_target = ($urandom % 3 == 0) ? $urandom_range(32'h2FF0, 32'h7010)
                                      : ($urandom_range(32'h3000, 32'h6FFC) & 32'hFFFF_FFFC);
      step();
      checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_pc n=%0d got %h exp %h", n, imem_addr, m_pc); end
      checks++; if (id_instr !== m_instr) begin errors++; $display("FAIL rnd_instr n=%0d got %h exp %h", n, id_instr, m_instr); end
      checks++; if (id_pc !== m_idpc || id_pc8 !== m_idpc + 8) begin errors++; $display("FAIL rnd_idpc n=%0d got %h/%h exp %h", n, id_pc, id_pc8, m_idpc); end
      checks++; if (id_valid !== m_valid || id_fetch_err !== m_err) begin errors++; $display("FAIL rnd_flags n=%0d got %b%b exp %b%b", n, id_valid, id_fetch_err, m_valid, m_err); end
    end
    stall = 0; npc_sel = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall_redirect();
    test_illegal();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage plus IF/ID pipeline register for the pipelined MIPS core.
- Holds the PC, drives the instruction memory address, and computes the next PC (sequential, branch, j/jal, jr/jalr).
- Registers the fetched word and its PC for the decode stage, where imm16 is split out to the immediate extender.
- Branch offsets arrive already sign-extended from the extender output of the instruction currently in ID.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- IMEM_LO, 32'h0000_3000, lowest legal fetch address.
- IMEM_HI, 32'h0000_6FFC, highest legal fetch address.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  hazard stall; freezes PC and IF/ID
- npc_sel  in  2  0=seq, 1=branch, 2=jump, 3=register jump (from ID-stage decode)
- br_taken  in  1  branch condition true (meaningful when npc_sel=1)
- br_offset  in  32  sign-extended imm16 of the ID instruction
- j_index  in  26  instr_index of the ID instruction
- jr_target  in  32  forwarded rs value for jr/jalr
- imem_addr  out  32  current PC, to instruction memory (combinational read)
- imem_rdata  in  32  instruction word at imem_addr
- id_instr  out  32  registered instruction for decode
- id_pc  out  32  registered PC of id_instr
- id_pc8  out  32  id_pc+8, link address for jal/jalr
- id_valid  out  1  id_instr is a real fetched instruction
- id_fetch_err  out  1  id_instr was fetched from an illegal PC

Behaviour:
- Reset (async, reset_n=0):
  - PC=PC_RESET.
  - id_instr=0 (nop), id_pc=0, id_valid=0, id_fetch_err=0.
  - id_pc8 follows id_pc combinationally, giving 8 during reset.
- imem_addr = PC, combinational. Fetch latency: the word at PC appears on id_instr one edge later.
- Next-PC selection (bases: pc4=PC+4, idpc4=id_pc+4; all arithmetic mod 2^32, wrap silently):
  - npc_sel=0: pc4.
  - npc_sel=1: br_taken ? idpc4 + (br_offset<<2) : pc4.
  - npc_sel=2: {idpc4[31:28], j_index, 2'b00}.
  - npc_sel=3: jr_target, unmodified.
- Redirect means npc_sel!=0, except npc_sel=1 with br_taken=0.
- Each rising edge with stall=0:
  - PC <= next PC.
  - id_instr <= imem_rdata, id_pc <= PC, id_valid <= 1.
  - Redirects apply only while id_valid=1; when id_valid=0, ID decode is forced to npc_sel=0 by the upstream decoder.
- stall=1 takes priority over everything:
  - PC and all id_* outputs hold.
  - Any redirect request in that cycle is ignored. The ID instruction is also held, so it re-asserts the redirect on the first unstalled cycle.
- Fetch check:
  - PC is illegal if PC[1:0]!=0, PC<IMEM_LO or PC>IMEM_HI.
  - On capture of an illegal PC: id_instr <= 0, id_valid <= 1, id_fetch_err <= 1.
  - Otherwise id_fetch_err <= 0.
  - PC itself is never corrected; the downstream exception logic owns recovery.
- Reset asserted mid-stall or mid-redirect: immediate return to reset values; the pending redirect is lost.

Optional Feature:
- Macro: IFU_DELAY_SLOT_EN.
- Defined (MIPS delay-slot semantics):
  - The instruction fetched in the same cycle as a redirect is captured normally into IF/ID, with id_valid=1.
  - Redirect targets take effect on the following fetch.
- Undefined (squash):
  - On an unstalled edge with a redirect, PC still updates, but IF/ID loads id_instr=0, id_valid=0, id_fetch_err=0.
  - id_pc takes the squashed PC.

Test Plan:
- Release reset, stall=0, npc_sel=0, imem returns addr^32'hFFFF: imem_addr=3000, 3004, 3008 on successive cycles; id_pc lags by one edge; id_pc8=id_pc+8; id_valid goes 1 after the first edge.
- Branch taken: id_pc=0x3004, npc_sel=1, br_taken=1, br_offset=32'hFFFF_FFFE → next PC=0x3000.
  - With IFU_DELAY_SLOT_EN: id_instr = word at 0x3008.
  - Without it: id_valid=0.
- Jump and register jump:
  - npc_sel=2, id_pc=0x3010, j_index=26'h0000C10 → PC=0x0000_3040.
  - npc_sel=3, jr_target=0x0000_3100 → PC=0x3100.
- Stall with redirect: stall=1 for 3 cycles while npc_sel=2 → PC and id_* frozen. Redirect happens on the first cycle after stall drops.
- Illegal fetch:
  - jr_target=0x0000_3002 → id_fetch_err=1, id_instr=0 next edge.
  - jr_target=0x0000_7000 → same response.
- Reset: assert reset_n=0 asynchronously mid-clock while PC=0x3040 → PC=0x3000 and id_valid=0 immediately, before the next edge.
